// File: rtl/store_writer.sv
// Store writer: drains one committed store into byte-wide RAM writes through an arbitrated port.
// Optional macro STORE_WRITER_IO_STALL_EN holds I/O-mapped bytes while the UART buffer is full.
module store_writer #(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rob_store_sgn,
    input  logic [5:0]  rob_store_op,
    input  logic [31:0] rob_store_addr,
    input  logic [31:0] rob_store_data,
    output logic        begin_real_store,
    output logic        finish_store,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    output logic        busy
);

    // Store opcodes, matching the encodings in defines.v
    localparam logic [5:0] OP_SB = 6'd29;
    localparam logic [5:0] OP_SH = 6'd30;
    localparam logic [5:0] OP_SW = 6'd31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [5:0]  op_reg, op_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] data_reg, data_next;
    logic        begin_reg, begin_next;
    logic        finish_reg, finish_next;
    logic        mem_req_reg, mem_req_next;
    logic [31:0] mem_a_reg, mem_a_next;
    logic [7:0]  mem_dout_reg, mem_dout_next;
    logic        mem_wr_reg, mem_wr_next;
    logic        busy_reg, busy_next;

    logic [7:0]  data_bytes [4];
    logic [2:0]  byte_total;
    logic [31:0] cur_addr;
    logic [7:0]  cur_byte;
    logic        last_byte;
    logic        io_stall;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign data_bytes[gi] = data_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_total = 3'd4;
        case (op_reg)
            OP_SB:   byte_total = 3'd1;
            OP_SH:   byte_total = 3'd2;
            OP_SW:   byte_total = 3'd4;
            default: byte_total = 3'd4;
        endcase
    end

    // Address wraps naturally modulo 2^32
    assign cur_addr  = addr_reg + {29'd0, cnt_reg};
    assign cur_byte  = data_bytes[cnt_reg[1:0]];
    assign last_byte = ((cnt_reg + 3'd1) == byte_total);

`ifdef STORE_WRITER_IO_STALL_EN
    assign io_stall = (cur_addr[17:16] == IO_SEL) && io_buffer_full;
`else
    logic unused_io_cfg;
    assign unused_io_cfg = io_buffer_full ^ (^IO_SEL);
    assign io_stall      = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        op_next       = op_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        begin_next    = begin_reg;
        finish_next   = finish_reg;
        mem_req_next  = mem_req_reg;
        mem_a_next    = mem_a_reg;
        mem_dout_next = mem_dout_reg;
        mem_wr_next   = mem_wr_reg;
        busy_next     = busy_reg;

        // rdy low leaves every register at its current value
        if (rdy) begin
            case (state_reg)
                IDLE: begin
                    begin_next    = 1'b0;
                    finish_next   = 1'b0;
                    mem_wr_next   = 1'b0;
                    mem_dout_next = 8'd0;
                    mem_req_next  = 1'b0;
                    if (rob_store_sgn) begin
                        op_next      = rob_store_op;
                        addr_next    = rob_store_addr;
                        data_next    = rob_store_data;
                        cnt_next     = 3'd0;
                        begin_next   = 1'b1;
                        mem_req_next = 1'b1;
                        busy_next    = 1'b1;
                        state_next   = WRITE;
                    end
                end
                WRITE: begin
                    begin_next    = 1'b0;
                    mem_wr_next   = 1'b0;
                    mem_dout_next = 8'd0;
                    if (mem_gnt && !io_stall) begin
                        mem_wr_next   = 1'b1;
                        mem_a_next    = cur_addr;
                        mem_dout_next = cur_byte;
                        cnt_next      = cnt_reg + 3'd1;
                        if (last_byte) begin
                            mem_req_next = 1'b0;
                            state_next   = DONE;
                        end
                    end
                end
                DONE: begin
                    finish_next   = 1'b1;
                    mem_wr_next   = 1'b0;
                    mem_dout_next = 8'd0;
                    mem_req_next  = 1'b0;
                    busy_next     = 1'b0;
                    state_next    = IDLE;
                end
                default: begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 3'd0;
            op_reg       <= 6'd0;
            addr_reg     <= 32'd0;
            data_reg     <= 32'd0;
            begin_reg    <= 1'b0;
            finish_reg   <= 1'b0;
            mem_req_reg  <= 1'b0;
            mem_a_reg    <= 32'd0;
            mem_dout_reg <= 8'd0;
            mem_wr_reg   <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            op_reg       <= op_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            begin_reg    <= begin_next;
            finish_reg   <= finish_next;
            mem_req_reg  <= mem_req_next;
            mem_a_reg    <= mem_a_next;
            mem_dout_reg <= mem_dout_next;
            mem_wr_reg   <= mem_wr_next;
            busy_reg     <= busy_next;
        end
    end

    assign begin_real_store = begin_reg;
    assign finish_store     = finish_reg;
    assign mem_req          = mem_req_reg;
    assign mem_a            = mem_a_reg;
    assign mem_dout         = mem_dout_reg;
    assign mem_wr           = mem_wr_reg;
    assign busy             = busy_reg;

endmodule
